// File: rtl/mux_rr_reg_pkg.sv
// Shared definitions for the registered N-channel bus selector:
// output-register state encoding and selection-mode constants.
package mux_rr_reg_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// found searching upward from ptr+1, wrapping CHANNELS-1 -> 0.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] idx;

    always_comb begin
        // NOTE: every output and temporary gets a default before the search
        // loop, so no path through the block leaves a value held (no latch).
        grant       = '0;
        grant_valid = 1'b0;
        idx         = ptr;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (idx == LAST) ? '0 : idx + 1'b1;
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-channel W-bit bus selector with valid/ready on both sides;
// picks a producer by explicit select (MODE_SEL) or round-robin (MODE_RR).
module mux_rr_reg
    import mux_rr_reg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int MODE     = MODE_SEL
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    state_e                 state;
    state_e                 state_next;
    logic [SEL_W-1:0]       grant;
    logic                   grant_valid;
    logic                   can_load;
    logic                   load;
    logic [CHANNELS-1:0]    hit;
    logic [CHANNELS:0][WIDTH-1:0] or_chain;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;
            logic             sel_unused;

            assign sel_unused = ^sel;

            rr_arbiter #(
                .CHANNELS (CHANNELS),
                .SEL_W    (SEL_W)
            ) u_arb (
                .req         (in_valid),
                .ptr         (ptr),
                .grant       (grant),
                .grant_valid (grant_valid)
            );

            // ptr only advances on an accepted transfer, never on stalls.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ptr <= SEL_W'(CHANNELS - 1);
                end else if (load) begin
                    ptr <= grant;
                end
            end
        end else begin : g_sel
            // Zero-extended so an out-of-range sel reads a 0 request bit.
            logic [2**SEL_W-1:0] valid_ext;

            always_comb begin
                valid_ext                 = '0;
                valid_ext[CHANNELS-1:0]   = in_valid;
            end

            assign grant       = sel;
            assign grant_valid = valid_ext[sel];
        end
    endgenerate

    assign can_load = (state == ST_EMPTY) || out_ready;
    assign load     = grant_valid && can_load && !reset;

    // One-hot decode of the grant drives both in_ready and the data mux.
    assign or_chain[0] = '0;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign hit[i]        = (grant == SEL_W'(i));
        assign in_ready[i]   = load && hit[i];
        assign or_chain[i+1] = or_chain[i] | (hit[i] ? in_data[i*WIDTH +: WIDTH] : '0);
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = ST_FULL;
        end else if ((state == ST_FULL) && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= ST_EMPTY;
            // NOTE: the data/channel registers are reset as well, because a
            // discarded word must read back as 0 after reset.
            out_data <= '0;
            out_chan <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                out_data <= or_chain[CHANNELS];
                out_chan <= grant;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench for mux_rr_reg: three instances (select/4ch, round-robin/4ch,
// select/3ch) share a clock; a reference model predicts handshakes and words.
module tb_mux_rr_reg;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  chan;
    } pkt_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0][63:0] in_data;
    logic [2:0][3:0]  in_valid;
    logic [2:0][3:0]  in_ready;
    logic [2:0][1:0]  sel;
    logic [2:0][15:0] out_data;
    logic [2:0][1:0]  out_chan;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;

    assign in_ready[2][3] = 1'b0;

    mux_rr_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2), .MODE(0)) u_sel4 (
        .clock(clock), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sel(sel[0]), .out_data(out_data[0]),
        .out_chan(out_chan[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

    mux_rr_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2), .MODE(1)) u_rr4 (
        .clock(clock), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sel(sel[1]), .out_data(out_data[1]),
        .out_chan(out_chan[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

    mux_rr_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2), .MODE(0)) u_sel3 (
        .clock(clock), .reset(reset), .in_data(in_data[2][47:0]), .in_valid(in_valid[2][2:0]),
        .in_ready(in_ready[2][2:0]), .sel(sel[2]), .out_data(out_data[2]),
        .out_chan(out_chan[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    int   total = 0;
    int   bad   = 0;
    pkt_t q0[$];
    pkt_t q1[$];
    pkt_t q2[$];
    bit   full[3];
    int   ptr_m = 3;

    function automatic int grant_sel(logic [3:0] v, int s, int ch);
        if (s < ch && v[s]) return s;
        return -1;
    endfunction

    function automatic int grant_rr(logic [3:0] v, int p, int ch);
        for (int k = 1; k <= ch; k++) begin
            if (v[(p + k) % ch]) return (p + k) % ch;
        end
        return -1;
    endfunction

    task automatic q_push(int i, pkt_t p);
        case (i)
            0: q0.push_back(p);
            1: q1.push_back(p);
            default: q2.push_back(p);
        endcase
    endtask

    task automatic q_pop(int i);
        case (i)
            0: if (q0.size() > 0) void'(q0.pop_front());
            1: if (q1.size() > 0) void'(q1.pop_front());
            default: if (q2.size() > 0) void'(q2.pop_front());
        endcase
    endtask

    task automatic q_clear(int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic pkt_t q_front(int i);
        pkt_t f = '0;
        case (i)
            0: if (q0.size() > 0) f = q0[0];
            1: if (q1.size() > 0) f = q1[0];
            default: if (q2.size() > 0) f = q2[0];
        endcase
        return f;
    endfunction

    task automatic set_data();
        for (int i = 0; i < 3; i++) in_data[i] = {$urandom, $urandom};
    endtask

    // One clock: predict in_ready before the edge, then compare the output
    // register against the scoreboard after the edge.
    task automatic tick();
        int   g[3];
        bit   acc[3];
        pkt_t p[3];
        #1;
        for (int i = 0; i < 3; i++) begin
            int         ch;
            logic [3:0] m;
            logic [3:0] v;
            logic [3:0] er;
            bit         can;
            ch = (i == 2) ? 3 : 4;
            m  = (i == 2) ? 4'h7 : 4'hF;
            v  = in_valid[i] & m;
            if (reset)       g[i] = -1;
            else if (i == 1) g[i] = grant_rr(v, ptr_m, ch);
            else             g[i] = grant_sel(v, int'(sel[i]), ch);
            can    = !full[i] || out_ready[i];
            er     = (g[i] >= 0 && can) ? (4'b0001 << g[i]) : 4'b0000;
            acc[i] = (er != 4'b0000);
            p[i]   = '0;
            if (acc[i]) p[i] = '{data: in_data[i][g[i]*16 +: 16], chan: 2'(g[i])};
            total++;
            if ((in_ready[i] & m) !== er) begin
                bad++;
                $display("FAIL in_ready dut%0d: got %b want %b", i, in_ready[i] & m, er);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            pkt_t f;
            if (reset) begin
                full[i] = 1'b0;
                q_clear(i);
                if (i == 1) ptr_m = 3;
            end else begin
                if (full[i] && out_ready[i]) q_pop(i);
                if (acc[i]) begin
                    q_push(i, p[i]);
                    if (i == 1) ptr_m = g[i];
                end
                full[i] = acc[i] || (full[i] && !out_ready[i]);
            end
            total++;
            if (out_valid[i] !== full[i]) begin
                bad++;
                $display("FAIL out_valid dut%0d: got %b want %b", i, out_valid[i], full[i]);
            end
            if (full[i]) begin
                f = q_front(i);
                total++;
                if ({out_data[i], out_chan[i]} !== f) begin
                    bad++;
                    $display("FAIL out_word dut%0d: got %h/%0d want %h/%0d",
                             i, out_data[i], out_chan[i], f.data, f.chan);
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        out_ready   = 3'b111;
        in_valid[0] = 4'hF;
        in_valid[1] = 4'hF;
        set_data();
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (in_ready[1] !== 4'b0000 || in_ready[0] !== 4'b0000) begin
                bad++;
                $display("FAIL reset_in_ready: got %b/%b want 0000", in_ready[0], in_ready[1]);
            end
            tick();
            total++;
            if (out_valid[1] !== 1'b0 || out_data[1] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_out: got v=%b d=%h want v=0 d=0000", out_valid[1], out_data[1]);
            end
        end
        reset = 1'b0;
        tick();
        total++;
        if (out_chan[1] !== 2'd0 || out_valid[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant: got chan=%0d v=%b want chan=0 v=1", out_chan[1], out_valid[1]);
        end
        in_valid[0] = 4'h0;
        in_valid[1] = 4'h0;
        tick();
    endtask

    task automatic test_sel_basic();
        in_valid[0]          = 4'b0100;
        sel[0]               = 2'd2;
        in_data[0][47:32]    = 16'hBEEF;
        out_ready[0]         = 1'b1;
        #1;
        total++;
        if (in_ready[0] !== 4'b0100) begin
            bad++;
            $display("FAIL sel_in_ready: got %b want 0100", in_ready[0]);
        end
        tick();
        total++;
        if (out_data[0] !== 16'hBEEF || out_chan[0] !== 2'd2 || out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL sel_word: got %h/%0d v=%b want beef/2 v=1", out_data[0], out_chan[0], out_valid[0]);
        end
        sel[0] = 2'd1;
        tick();
        total++;
        if (out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL sel_invalid_chan: got v=%b want v=0", out_valid[0]);
        end
        in_valid[0] = 4'h0;
    endtask

    task automatic test_sel_out_of_range();
        sel[2]       = 2'd3;
        in_valid[2]  = 4'b0111;
        out_ready[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_data();
            tick();
            total++;
            if (out_valid[2] !== 1'b0 || in_ready[2] !== 4'b0000) begin
                bad++;
                $display("FAIL sel_out_of_range: got v=%b rdy=%b want v=0 rdy=0000", out_valid[2], in_ready[2]);
            end
        end
        in_valid[2] = 4'h0;
    endtask

    task automatic test_rr_rotation();
        reset        = 1'b1;
        in_valid[1]  = 4'hF;
        out_ready[1] = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_data();
            tick();
            total++;
            if (out_chan[1] !== 2'(k % 4) || out_valid[1] !== 1'b1) begin
                bad++;
                $display("FAIL rr_rotation[%0d]: got chan=%0d v=%b want chan=%0d v=1",
                         k, out_chan[1], out_valid[1], k % 4);
            end
        end
    endtask

    task automatic test_back_pressure();
        in_valid[1]        = 4'b0001;
        in_data[1][15:0]   = 16'h1234;
        out_ready[1]       = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        in_valid[1]  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            set_data();
            #1;
            total++;
            if (in_ready[1] !== 4'b0000) begin
                bad++;
                $display("FAIL stall_in_ready: got %b want 0000", in_ready[1]);
            end
            tick();
            total++;
            if (out_data[1] !== 16'h1234 || out_chan[1] !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold: got %h/%0d want 1234/0", out_data[1], out_chan[1]);
            end
        end
        out_ready[1]      = 1'b1;
        in_data[1][31:16] = 16'h5678;
        tick();
        total++;
        if (out_data[1] !== 16'h5678 || out_chan[1] !== 2'd1) begin
            bad++;
            $display("FAIL stall_release: got %h/%0d want 5678/1", out_data[1], out_chan[1]);
        end
    endtask

    task automatic test_reset_while_full();
        out_ready[1] = 1'b0;
        in_valid[1]  = 4'hF;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== 16'h0000 || out_chan[1] !== 2'd0) begin
            bad++;
            $display("FAIL reset_full: got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                     out_valid[1], out_data[1], out_chan[1]);
        end
        reset        = 1'b0;
        out_ready[1] = 1'b1;
        set_data();
        tick();
        total++;
        if (out_chan[1] !== 2'd0) begin
            bad++;
            $display("FAIL reset_full_ptr: got chan=%0d want 0", out_chan[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 80; k++) begin
            set_data();
            for (int i = 0; i < 3; i++) begin
                in_valid[i]  = 4'($urandom);
                sel[i]       = 2'($urandom);
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
    endtask

    initial begin
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        out_ready = '0;
        @(negedge clock);
        test_reset();
        test_sel_basic();
        test_sel_out_of_range();
        test_rr_rotation();
        test_back_pressure();
        test_reset_while_full();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
